// File: rtl/cp0_ext_intc.sv
// cp0_ext_intc: Coprocessor-0 with a configurable number of HW interrupt lines
// (level or edge-latched), a Count/Compare timer on the top IP line, BadVAddr
// capture for address errors, and the M-stage flush request and EPC for eret.
module cp0_ext_intc #(
  parameter int          N_HWINT   = 6,
  parameter logic [5:0]  EDGE_MASK = 6'b000000,
  parameter bit          TIMER_EN  = 1'b1,
  parameter logic [31:0] PRID      = 32'h0000_0400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         CP0_i_Addr,
  input  logic [31:0]        CP0_i_WData,
  input  logic               CP0_i_WEnable,
  input  logic [31:0]        CP0_i_PCAtM,
  input  logic [31:0]        CP0_i_BadVAddr,
  input  logic [4:0]         CP0_i_ExcCode,
  input  logic               CP0_i_isBranch,
  input  logic               CP0_i_EXLClr,
  input  logic [N_HWINT-1:0] CP0_i_HWInt,
  output logic               CP0_o_IntReq,
  output logic [31:0]        CP0_o_EPC,
  output logic [31:0]        CP0_o_RData,
  output logic               CP0_o_TimerIRQ
);

  localparam int IP_LO = 10;

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_SR       = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;

  // architectural state
  logic [31:0]        badvaddr, count, compare, epc;
  logic [N_HWINT-1:0] im;
  logic               exl, ie, bd;
  logic [4:0]         exccode;
  logic               timer_irq;

  // edge sensing state
  logic [N_HWINT-1:0] edge_lat, hw_prev;

  logic [N_HWINT-1:0] ip, edge_set, edge_clr;
  logic               int_pend, int_req;
  logic               wr, wr_count, wr_compare, wr_sr, wr_cause, wr_epc;
  logic [31:0]        count_nxt;
  logic [31:0]        pc_al;

  // an accepted exception/interrupt swallows any same-cycle mtc0
  assign wr         = CP0_i_WEnable & ~int_req;
  assign wr_count   = wr & (CP0_i_Addr == A_COUNT);
  assign wr_compare = wr & (CP0_i_Addr == A_COMPARE);
  assign wr_sr      = wr & (CP0_i_Addr == A_SR);
  assign wr_cause   = wr & (CP0_i_Addr == A_CAUSE);
  assign wr_epc     = wr & (CP0_i_Addr == A_EPC);

  // per-line pending: live level lines or edge latches, timer ORed into the top line
  for (genvar k = 0; k < N_HWINT; k++) begin : g_line
    logic src;
    if (EDGE_MASK[k]) begin : g_edge
      assign src         = edge_lat[k];
      assign edge_set[k] = CP0_i_HWInt[k] & ~hw_prev[k];
      assign edge_clr[k] = wr_cause & ~CP0_i_WData[IP_LO+k];
    end else begin : g_level
      assign src         = CP0_i_HWInt[k];
      assign edge_set[k] = 1'b0;
      assign edge_clr[k] = 1'b0;
    end
    if (TIMER_EN && (k == N_HWINT-1)) begin : g_tmr
      assign ip[k] = src | timer_irq;
    end else begin : g_notmr
      assign ip[k] = src;
    end
  end

  assign int_pend = ie & ~exl & (|(ip & im));
  assign int_req  = reset & (int_pend | (CP0_i_ExcCode != 5'd0));

  // masking with ~3 rather than slicing keeps every PC bit in use
  assign pc_al = CP0_i_PCAtM & ~32'h3;

  // Count next value: an mtc0 load replaces the increment for that cycle
  always_comb begin
    count_nxt = count;
    if (wr_count)      count_nxt = CP0_i_WData;
    else if (TIMER_EN) count_nxt = count + 32'd1;
  end

  // edge latches: set beats a same-cycle clear, writing 1 leaves the latch alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_lat <= '0;
      hw_prev  <= '0;
    end else begin
      edge_lat <= edge_set | (edge_lat & ~edge_clr);
      hw_prev  <= CP0_i_HWInt;
    end
  end

  // timer: Count free-runs, Compare write clears the pending flag with priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      compare   <= '0;
      timer_irq <= 1'b0;
    end else begin
      count <= count_nxt;
      if (wr_compare) compare <= CP0_i_WData;
      if (!TIMER_EN)                  timer_irq <= 1'b0;
      else if (wr_compare)            timer_irq <= 1'b0;
      else if (count_nxt == compare)  timer_irq <= 1'b1;
    end
  end

  // exception entry beats eret, which beats mtc0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      badvaddr <= '0;
      epc      <= '0;
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exccode  <= '0;
    end else if (int_req) begin
      exl     <= 1'b1;
      bd      <= CP0_i_isBranch;
      exccode <= int_pend ? 5'd0 : CP0_i_ExcCode;
      epc     <= pc_al - (CP0_i_isBranch ? 32'd4 : 32'd0);
      if ((CP0_i_ExcCode == 5'd4) || (CP0_i_ExcCode == 5'd5))
        badvaddr <= CP0_i_BadVAddr;
    end else begin
      if (wr_sr) begin
        im  <= CP0_i_WData[IP_LO +: N_HWINT];
        ie  <= CP0_i_WData[0];
        exl <= CP0_i_WData[1];
      end
      if (CP0_i_EXLClr) exl <= 1'b0;
      if (wr_epc)       epc <= CP0_i_WData;
    end
  end

  // mfc0 read mux; Cause shows live IP
  always_comb begin
    CP0_o_RData = 32'h0;
    case (CP0_i_Addr)
      A_BADVADDR: CP0_o_RData = badvaddr;
      A_COUNT:    CP0_o_RData = count;
      A_COMPARE:  CP0_o_RData = compare;
      A_SR: begin
        CP0_o_RData[IP_LO +: N_HWINT] = im;
        CP0_o_RData[1]                = exl;
        CP0_o_RData[0]                = ie;
      end
      A_CAUSE: begin
        CP0_o_RData[31]               = bd;
        CP0_o_RData[IP_LO +: N_HWINT] = ip;
        CP0_o_RData[6:2]              = exccode;
      end
      A_EPC:      CP0_o_RData = epc;
      A_PRID:     CP0_o_RData = PRID;
      default:    CP0_o_RData = 32'h0;
    endcase
  end

  assign CP0_o_IntReq   = int_req;
  assign CP0_o_EPC      = (CP0_i_WEnable && (CP0_i_Addr == A_EPC)) ? CP0_i_WData : epc;
  assign CP0_o_TimerIRQ = timer_irq;

endmodule

// File: tb/tb_cp0_ext_intc.sv
// Scoreboard bench for cp0_ext_intc: stimulus pushes expected output values,
// a monitor pops and compares them on the falling edge.
module tb_cp0_ext_intc;

  localparam int N = 6;
  localparam int S_RDATA = 0, S_INTREQ = 1, S_EPC = 2, S_TIRQ = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    addr;
  logic [31:0]   wdata;
  logic          wen;
  logic [31:0]   pc;
  logic [31:0]   bva;
  logic [4:0]    exc;
  logic          isbr;
  logic          exlclr;
  logic [N-1:0]  hwint;
  logic          intreq;
  logic [31:0]   epc_o;
  logic [31:0]   rdata;
  logic          tirq;

  int passed = 0;
  int total  = 0;

  string       q_name[$];
  int          q_sel[$];
  logic [31:0] q_exp[$];

  cp0_ext_intc #(.N_HWINT(N), .EDGE_MASK(6'b000001), .TIMER_EN(1'b1), .PRID(32'h0000_0400)) dut (
    .clk(clk), .reset(reset),
    .CP0_i_Addr(addr), .CP0_i_WData(wdata), .CP0_i_WEnable(wen),
    .CP0_i_PCAtM(pc), .CP0_i_BadVAddr(bva), .CP0_i_ExcCode(exc),
    .CP0_i_isBranch(isbr), .CP0_i_EXLClr(exlclr), .CP0_i_HWInt(hwint),
    .CP0_o_IntReq(intreq), .CP0_o_EPC(epc_o), .CP0_o_RData(rdata),
    .CP0_o_TimerIRQ(tirq)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input string name, input int sel, input logic [31:0] v);
    q_name.push_back(name);
    q_sel.push_back(sel);
    q_exp.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    step();
    wen = 1'b0;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] v);
    addr = a;
    expect_v(name, S_RDATA, v);
    step();
  endtask

  task automatic eret();
    exlclr = 1'b1;
    step();
    exlclr = 1'b0;
  endtask

  // monitor: compare every queued expectation against the settled outputs
  initial begin
    forever begin
      @(negedge clk);
      while (q_sel.size() > 0) begin
        string       nm;
        int          sel;
        logic [31:0] ex, act;
        nm  = q_name.pop_front();
        sel = q_sel.pop_front();
        ex  = q_exp.pop_front();
        case (sel)
          S_RDATA:  act = rdata;
          S_INTREQ: act = {31'b0, intreq};
          S_EPC:    act = epc_o;
          default:  act = {31'b0, tirq};
        endcase
        total++;
        if (act === ex) passed++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, ex);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; addr = '0; wdata = '0; wen = 1'b0; pc = '0; bva = '0;
    exc = 5'd4; isbr = 1'b0; exlclr = 1'b0; hwint = '0;
    #1;
    expect_v("rst_intreq_forced0", S_INTREQ, 32'd0);
    step(); step();
    exc = 5'd0;
    reset = 1'b1;

    // reset values
    rd("rst_sr",    5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc",   5'd14, 32'h0);
    rd("rst_prid",  5'd15, 32'h0000_0400);
    rd("rst_unmap", 5'd3,  32'h0);
    expect_v("rst_intreq", S_INTREQ, 32'd0);

    // timer on line 5
    pc = 32'h0000_2000;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h0000_8001);
    rd("count_2", 5'd9, 32'd2);
    repeat (16) step();
    expect_v("count_19", S_RDATA, 32'd19);
    expect_v("tirq_before", S_TIRQ, 32'd0);
    expect_v("intreq_before", S_INTREQ, 32'd0);
    step();
    expect_v("count_20", S_RDATA, 32'd20);
    expect_v("tirq_set", S_TIRQ, 32'd1);
    expect_v("tirq_intreq", S_INTREQ, 32'd1);
    step();
    expect_v("intreq_exl", S_INTREQ, 32'd0);
    expect_v("tmr_epc_out", S_EPC, 32'h0000_2000);
    rd("tmr_sr",    5'd12, 32'h0000_8003);
    rd("tmr_cause", 5'd13, 32'h0000_8000);
    mtc0(5'd11, 32'd100);
    expect_v("tirq_clr", S_TIRQ, 32'd0);
    mtc0(5'd11, 32'hFFFF_0000);
    eret();
    expect_v("tmr_eret_intreq", S_INTREQ, 32'd0);

    // edge line 0
    mtc0(5'd12, 32'h0000_0401);
    addr = 5'd13;
    hwint[0] = 1'b1;
    expect_v("edge_same_cycle", S_INTREQ, 32'd0);
    step();
    hwint[0] = 1'b0;
    expect_v("edge_intreq", S_INTREQ, 32'd1);
    expect_v("edge_cause_ip0", S_RDATA, 32'h0000_0400);
    step();
    expect_v("edge_exl", S_INTREQ, 32'd0);
    eret();
    expect_v("edge_still_pend", S_INTREQ, 32'd1);
    expect_v("edge_cause_pend", S_RDATA, 32'h0000_0400);
    step();
    mtc0(5'd13, 32'h0);
    expect_v("edge_cause_clr", S_RDATA, 32'h0);
    eret();
    expect_v("edge_cleared", S_INTREQ, 32'd0);

    // address exception in a delay slot
    mtc0(5'd12, 32'h0);
    pc = 32'h0000_3008; isbr = 1'b1; bva = 32'h0000_0003; exc = 5'd4;
    expect_v("exc_intreq", S_INTREQ, 32'd1);
    step();
    exc = 5'd0; isbr = 1'b0; bva = 32'h0;
    rd("exc_epc",   5'd14, 32'h0000_3004);
    rd("exc_cause", 5'd13, 32'h8000_0010);
    rd("exc_bva",   5'd8,  32'h0000_0003);
    eret();

    // interrupt beats exception, mtc0 dropped
    mtc0(5'd12, 32'h0000_1001);
    pc = 32'h0000_4000;
    hwint[2] = 1'b1; exc = 5'd10;
    addr = 5'd14; wdata = 32'h0000_1234; wen = 1'b1;
    expect_v("sim_intreq", S_INTREQ, 32'd1);
    expect_v("sim_epc_bypass", S_EPC, 32'h0000_1234);
    step();
    wen = 1'b0; hwint[2] = 1'b0; exc = 5'd0;
    rd("sim_epc",   5'd14, 32'h0000_4000);
    rd("sim_cause", 5'd13, 32'h0);
    eret();
    mtc0(5'd12, 32'h0);

    // mtc0 EPC bypass
    addr = 5'd14; wdata = 32'h0000_3100; wen = 1'b1;
    expect_v("bypass_same", S_EPC, 32'h0000_3100);
    step();
    wen = 1'b0;
    expect_v("bypass_reg", S_EPC, 32'h0000_3100);
    step();

    // asynchronous reset in the middle of a timer run
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    addr = 5'd9;
    repeat (8) step();
    expect_v("pre_rst_tirq", S_TIRQ, 32'd1);
    step();
    reset = 1'b0;
    #1;
    expect_v("async_rst_tirq", S_TIRQ, 32'd0);
    expect_v("async_rst_count", S_RDATA, 32'd0);
    expect_v("async_rst_intreq", S_INTREQ, 32'd0);
    step();
    step();

    if (q_sel.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", q_sel.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cp0_ext_intc.md
Name: cp0_ext_intc

Overview:
Parametrised Coprocessor-0 successor sitting at the M stage beside the pipeline's exception/interrupt arbitration. It adds several features:
- configurable hardware-interrupt line count, with per-line level or edge-latched sensing;
- an internal Count/Compare timer whose interrupt drives the top IP line;
- a BadVAddr register for address exceptions;
- deterministic reads of unmapped addresses.
It raises the pipeline flush request and supplies EPC for eret.

Parameters:
N_HWINT, 6, number of IP/IM lines (1..6); IP/IM occupy bits [10+N_HWINT-1:10] of Cause/SR
EDGE_MASK, 6'b000000, bit k=1: line k is edge-latched, 0: level
TIMER_EN, 1, 1: Count increments and the timer drives IP line N_HWINT-1
PRID, 32'h00000400, PRId read value

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
CP0_i_Addr  input  5  CP0 register number for mfc0/mtc0
CP0_i_WData  input  32  mtc0 data
CP0_i_WEnable  input  1  mtc0 write strobe
CP0_i_PCAtM  input  32  PC of the M-stage instruction
CP0_i_BadVAddr  input  32  faulting address from the M stage
CP0_i_ExcCode  input  5  [6:2] exception code, 0 = none
CP0_i_isBranch  input  1  M-stage instruction is in a delay slot
CP0_i_EXLClr  input  1  eret in M
CP0_i_HWInt  input  N_HWINT  external interrupt lines
CP0_o_IntReq  output  1  flush/vector request
CP0_o_EPC  output  32  EPC, with mtc0 bypass
CP0_o_RData  output  32  mfc0 read data
CP0_o_TimerIRQ  output  1  timer pending flag (debug/observe)

Behaviour:
Register map:
- 8 BadVAddr
- 9 Count
- 11 Compare
- 12 SR {IM, EXL[1], IE[0]}
- 13 Cause {BD[31], IP, ExcCode[6:2]}
- 14 EPC
- 15 PRId
- Any other address reads 32'h0.

Reset:
- While reset=0, all registers are 0 (PRId constant), edge latches and previous-sample flops are 0, TimerIRQ=0.
- IntReq is forced to 0 while reset=0.

Pending IP line k:
- Level lines: IP[k] = HWInt[k], live.
- Edge lines: the latch sets on the cycle after HWInt[k] goes 0→1 (rising edge against the registered previous sample). The latch holds until an mtc0 to Cause writes 0 to that IP bit. Writing 1 has no effect. A set in the same cycle as a clear wins.
- Timer (TIMER_EN=1): IP[N_HWINT-1] is the OR of the timer pending and the HWInt line.

Timer:
- Count increments by 1 every cycle and wraps at 2^32.
- mtc0 Count loads WData; it is not incremented that cycle.
- TimerIRQ sets at the edge where Count's next value equals Compare.
- mtc0 Compare loads Compare and clears TimerIRQ; the clear has priority over a same-cycle set.
- Count keeps running during IntReq/EXL.

IntReq:
- IntReq = (IE & ~EXL & |(IP & IM)) | (ExcCode != 0), combinational.

Update priority per edge: IntReq > EXLClr > mtc0.
- On IntReq:
  - EXL <= 1.
  - BD <= isBranch.
  - Cause.ExcCode <= 0 if an interrupt is pending, otherwise the input ExcCode (interrupts beat exceptions).
  - EPC <= {PCAtM[31:2],2'b0} - (isBranch ? 4 : 0).
  - BadVAddr <= input when ExcCode is 4 or 5.
  - mtc0 is dropped.
- EXLClr: EXL <= 0.
- mtc0 SR: only the IM, EXL and IE bits are writable.
- mtc0 Cause: only edge-line IP bits are affected (clear-only).
- mtc0 EPC: EPC loads WData.
- Writes to BadVAddr and PRId are ignored.

Outputs:
- RData is combinational; Cause reads return live IP.
- CP0_o_EPC = WData when WEnable & Addr==14, otherwise EPC.

Test Plan:
- Reset release, then mfc0 addresses 12/13/14/15/3 → 0, 0, 0, 32'h00000400, 0; IntReq=0.
- Timer: write SR=32'h00008001 (IM line 5, IE), Compare=20, Count=0 → TimerIRQ=1 and IntReq=1 at the edge where Count reaches 20. Cause.ExcCode=0 and EXL=1 next cycle. Write Compare=100 → TimerIRQ=0.
- Edge line 0 (EDGE_MASK=6'b000001): pulse HWInt[0] for 1 cycle with IM0=1, IE=1 → IntReq one cycle later. After eret, the line is still pending until Cause is written with IP0=0, then IntReq=0.
- Exception ExcCode=4 at PC 32'h00003008 with isBranch=1, BadVAddr=32'h00000003 → EPC=32'h00003004, BD=1, BadVAddr=32'h00000003.
- Simultaneous level interrupt on line 2 and ExcCode=10 → Cause.ExcCode=0. A same-cycle mtc0 EPC=32'h1234 is dropped; EPC = the PC.
- mtc0 EPC=32'h00003100 without IntReq → CP0_o_EPC=32'h00003100 in the same cycle. Assert reset mid-timer → Count=0 and TimerIRQ=0 immediately (asynchronous).
